result_display: RTL and testbench
=================================

# result_display

Sequential display back-end that sits directly downstream of `calculator_top`. On a `load` strobe (driven from `complete`), it takes the signed 16-bit `display_output` word and converts its magnitude to 5 BCD digits using a 16-iteration double-dabble. It then drives a 6-position multiplexed, active-low 7-segment display: position 5 shows the sign, positions 4..0 show the digits.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each display position stays lit; legal values ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `value`  in  16  two's-complement result, sampled only on an accepted `load`.
- `load`  in  1  single-cycle request to convert `value`.
- `busy`  out  1  high while a conversion runs; `load` is ignored while high.
- `done`  out  1  one-cycle pulse when new `bcd`/`negative` are valid.
- `bcd`  out  20  5 BCD digits; [19:16] is the ten-thousands digit, [3:0] the ones digit.
- `negative`  out  1  sign of the last converted value.
- `seg_n`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- `an_n`  out  6  active-low one-hot position select; bit 5 is the sign, bits 4..0 are digits.

## Operation
- **States.** IDLE, CONV, DONE.
  - IDLE → CONV on `load`.
  - CONV → DONE after 16 shift cycles.
  - DONE → IDLE after one cycle.
  - `load` is accepted in IDLE and in DONE. In DONE it goes directly to CONV, and `done` still pulses.
- **Capture.** On the accepting edge, register `neg_q = value[15]` and `mag = value[15] ? (~value + 1) : value` as 16-bit unsigned. 0x8000 gives mag = 32768, which needs no extra bit.
- **Double-dabble, one iteration per CONV cycle.**
  - Add 3 to every BCD nibble that is ≥ 5.
  - Then shift the {bcd_work[19:0], bin[15:0]} register left by 1.
  - A 5-bit iteration counter runs 0..15.
- **Output registers.** `bcd` and `negative` update only on the CONV → DONE edge. During a conversion, the display keeps the previous result, so the display path is double-buffered.
- **Scan counter.** A prescaler counts to `SCAN_DIV`−1, then advances the position 0→1→…→5→0. Exactly one `an_n` bit is low at a time. Scanning runs continuously from reset.
- **Digit encoding (active-low).** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111; minus=0111111 (g only).
- **Leading-zero blanking.**
  - Digits above the most significant non-zero digit show blank.
  - Digit 0 is never blanked.
- **Sign position.** Shows minus when `negative`=1, otherwise blank.
- **Before any conversion.** After reset, `bcd`=0 and `negative`=0, so the display shows "0" at position 0 and blanks elsewhere.

## Timing
- **Reset values.** On the `RST` edge:
  - state = IDLE; `busy`=0, `done`=0, `bcd`=0x00000, `negative`=0.
  - Scan position and prescaler = 0, `an_n`=111110, `seg_n`=1000000.
- **Latency.** `load` is sampled at edge N.
  - `busy`=1 from after edge N through edge N+16.
  - The shifts occur at edges N+1..N+16.
  - `bcd`, `negative` and `done`=1 appear after edge N+16; `busy`=0 in that same cycle.
  - Total: 16 cycles from the load edge to `done`.
- **Busy handling.** `load` while `busy`=1 is dropped with no queueing, and `value` is not resampled.
- **Back-to-back loads.** `load` in the DONE cycle is accepted; `busy` returns to 1 after that edge.
- **Reset mid-conversion.** `RST` wins over everything. The partial result is discarded, outputs return to reset values, and no `done` pulse is generated.
- **Segment timing.** `seg_n` and `an_n` are registered and change on the same edge, so there is no glitch between position and segment pattern. Each position is held for exactly `SCAN_DIV` cycles.
- **Scan independence.** The scan prescaler is independent of conversion state and is not disturbed by `load`.

## Test plan
- **Positive value.** `value`=12 (0x000C) with `load` → 16 cycles later `done`=1, `bcd`=0x00012, `negative`=0. Positions 4..2 are blank, position 1 shows 1111001, position 0 shows 0100100.
- **Negative value.** `value`=0xFFFE (−2) → `bcd`=0x00002, `negative`=1. Position 5 shows 0111111; only position 0 shows a digit, 0100100.
- **Full-scale negative.** `value`=0x8000 → `bcd`=0x32768, `negative`=1. Then `value`=0x7FFF → `bcd`=0x32767, `negative`=0.
- **Zero and busy handling.** `value`=0 → `bcd`=0x00000, position 0 shows 1000000. A second `load` with 0x0007 at cycle 5 of CONV is ignored. A `load` in the DONE cycle is accepted and yields 0x00007 16 cycles later.
- **Reset mid-conversion.** Assert `RST` at cycle 8 of a conversion of 0x1234 → no `done` pulse, `bcd`=0x00000, `busy`=0 on the next cycle.
- **Scan order.** With `SCAN_DIV`=4 → `an_n` steps 111110, 111101, 111011, 110111, 101111, 011111 every 4 cycles and wraps, with exactly one low bit at every cycle.

Source files
------------

// File: rtl/result_display.sv
// Display back-end: converts a signed 16-bit result to sign + 5 BCD digits
// and scans them onto a 6-position active-low multiplexed 7-segment display.
module result_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        negative,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    iter_q, iter_d;
  logic [35:0]   work_q, work_d;      // {bcd_work[19:0], bin[15:0]}
  logic          neg_work_q, neg_work_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          negative_q, negative_d;
  logic [19:0]   adj;
  logic [15:0]   mag;
  logic          accept;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    pos_q, pos_d;
  logic [5:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [3:0]    digit;
  logic          shown;
  logic [4:0]    lit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++) begin
      adj[4*i +: 4] = (work_q[16+4*i +: 4] >= 4'd5) ? work_q[16+4*i +: 4] + 4'd3
                                                      : work_q[16+4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    work_d     = work_q;
    neg_work_d = neg_work_q;
    bcd_d      = bcd_q;
    negative_d = negative_q;
    accept     = load && (state_q != S_CONV);
    mag        = value[15] ? (~value + 16'd1) : value;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d    = S_CONV;
          iter_d     = '0;
          work_d     = {20'd0, mag};
          neg_work_d = value[15];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        work_d = {adj, work_q[15:0]} << 1;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd15) begin
          state_d    = S_DONE;
          bcd_d      = work_d[35:16];
          negative_d = neg_work_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan path: position and segment pattern are both computed for the next
  // cycle and registered together, so an_n and seg_n never disagree.
  always_comb begin
    presc_d = presc_q + PW'(1);
    pos_d   = pos_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      pos_d   = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
    end
    an_n_d = ~(6'd1 << pos_d);

    lit[4] = |bcd_q[19:16];
    lit[3] = lit[4] | (|bcd_q[15:12]);
    lit[2] = lit[3] | (|bcd_q[11:8]);
    lit[1] = lit[2] | (|bcd_q[7:4]);
    lit[0] = 1'b1;

    digit = bcd_q[3:0];
    shown = 1'b1;
    case (pos_d)
      3'd0:    begin digit = bcd_q[3:0];   shown = lit[0]; end
      3'd1:    begin digit = bcd_q[7:4];   shown = lit[1]; end
      3'd2:    begin digit = bcd_q[11:8];  shown = lit[2]; end
      3'd3:    begin digit = bcd_q[15:12]; shown = lit[3]; end
      3'd4:    begin digit = bcd_q[19:16]; shown = lit[4]; end
      default: begin digit = 4'd0;         shown = 1'b0;   end
    endcase

    if (pos_d == 3'd5) begin
      seg_n_d = negative_q ? SEG_MINUS : SEG_BLANK;
    end else begin
      seg_n_d = shown ? seg_of(digit) : SEG_BLANK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      presc_q    <= '0;
      pos_q      <= '0;
      an_n_q     <= 6'b111110;
      seg_n_q    <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      negative_q <= negative_d;
      presc_q    <= presc_d;
      pos_q      <= pos_d;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  // NOTE: the conversion datapath has no reset; it is always loaded on the
  // accepting edge before the FSM ever reads it.
  always_ff @(posedge clk) begin
    iter_q     <= iter_d;
    work_q     <= work_d;
    neg_work_q <= neg_work_d;
  end

  assign busy     = (state_q == S_CONV);
  assign done     = (state_q == S_DONE);
  assign bcd      = bcd_q;
  assign negative = negative_q;
  assign seg_n    = seg_n_q;
  assign an_n     = an_n_q;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: results are modelled at load time and
// compared when done pulses; display contents checked per scan position.
module tb_result_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        busy, done, negative;
  logic [19:0] bcd;
  logic [6:0]  seg_n;
  logic [5:0]  an_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [20:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .RST(rst), .value(value), .load(load), .busy(busy), .done(done),
    .bcd(bcd), .negative(negative), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] exp_res(input logic [15:0] v);
    int m;
    logic [19:0] r;
    m = v[15] ? 65536 - int'(v) : int'(v);
    r[3:0]   = 4'(m % 10);
    r[7:4]   = 4'((m / 10) % 10);
    r[11:8]  = 4'((m / 100) % 10);
    r[15:12] = 4'((m / 1000) % 10);
    r[19:16] = 4'((m / 10000) % 10);
    return {v[15], r};
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] disp_model(input int pos, input logic [19:0] b, input logic neg);
    int msd;
    if (pos == 5) return neg ? 7'b0111111 : 7'b1111111;
    msd = 0;
    for (int i = 0; i < 5; i++) if (b[4*i +: 4] != 4'd0) msd = i;
    if (pos > msd) return 7'b1111111;
    return seg_digit(b[4*pos +: 4]);
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", {11'd0, negative, bcd}, {11'd0, mon_e.res});
        check("done_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input bit accept);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (accept) sb.push_back('{exp_res(v), cyc + 16});
    check(accept ? "busy_after_load" : "busy_during_ignored_load", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_results();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("pending_results", sb.size(), 0);
    sb.delete();
    tick(2);
  endtask

  task automatic check_disp(input logic [15:0] v);
    logic [20:0] e;
    logic [5:0]  want_an;
    bit          found;
    e = exp_res(v);
    for (int p = 0; p < 6; p++) begin
      want_an = ~(6'd1 << p);
      found = 0;
      for (int i = 0; i < 6 * SCAN_DIV + 4 && !found; i++) begin
        @(negedge clk);
        if (an_n == want_an) found = 1;
      end
      check("disp_pos_reached", {31'd0, found}, 32'd1);
      check("disp_seg", {25'd0, seg_n}, {25'd0, disp_model(p, e[19:0], e[20])});
    end
  endtask

  initial begin
    int saved;
    logic [5:0] exp_an;

    // Reset values and continuous scan order.
    tick(2);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_negative", {31'd0, negative}, 32'd0);
    check("rst_an_n", {26'd0, an_n}, 32'b111110);
    check("rst_seg_n", {25'd0, seg_n}, 32'b1000000);
    rst = 1'b0;
    for (int k = 1; k <= 6 * SCAN_DIV * 2; k++) begin
      @(posedge clk);
      #1;
      exp_an = ~(6'd1 << ((k / SCAN_DIV) % 6));
      check("scan_an_n", {26'd0, an_n}, {26'd0, exp_an});
      check("scan_onehot", $countones(~an_n), 1);
      check("scan_seg_n", {25'd0, seg_n},
            {25'd0, (((k / SCAN_DIV) % 6) == 0) ? 7'b1000000 : 7'b1111111});
    end

    // Positive, negative and full-scale values.
    do_load(16'h000C, 1); wait_results(); check_disp(16'h000C);
    do_load(16'hFFFE, 1); wait_results(); check_disp(16'hFFFE);
    do_load(16'h8000, 1); wait_results(); check_disp(16'h8000);
    do_load(16'h7FFF, 1); wait_results(); check_disp(16'h7FFF);

    // Zero, ignored load during CONV, accepted load in DONE.
    do_load(16'h0000, 1);
    tick(4);
    do_load(16'h0007, 0);
    tick(11);
    check("done_cycle_done", {31'd0, done}, 32'd1);
    check("done_cycle_busy", {31'd0, busy}, 32'd0);
    check("zero_bcd", {12'd0, bcd}, 32'd0);
    do_load(16'h0007, 1);
    wait_results();
    check_disp(16'h0007);

    // Reset mid-conversion: no done, outputs back to reset values.
    do_load(16'h1234, 1);
    tick(7);
    rst = 1'b1;
    sb.delete();
    saved = done_cnt;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_bcd", {12'd0, bcd}, 32'd0);
    check("midrst_negative", {31'd0, negative}, 32'd0);
    tick(30);
    check("midrst_no_done", done_cnt, saved);
    check("midrst_bcd_later", {12'd0, bcd}, 32'd0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
